// File: rtl/ls74157_quad_mux.sv
// ls74157_quad_mux
//
// Quad 2-to-1 data selector modelled on the 74LS157. It is used for datapath
// source selection in the CPU. The block also holds a registered shadow of the
// mux result and a registered enable flag for downstream synchronous logic.
//
// Parameters:
//   WIDTH     - width of a, b, y and y_q (one 74157 is 4 bits wide)
//
// Ports:
//   clk       in   1      system clock; all registers update on the rising edge
//   rst       in   1      synchronous reset, active-high (clears y_q and en_q)
//   a         in   WIDTH  data input A, selected when select = 0
//   b         in   WIDTH  data input B, selected when select = 1
//   select    in   1      source select: 0 = A, 1 = B
//   enable_n  in   1      active-low strobe: 1 forces the mux result to 0
//   y         out  WIDTH  mux output (combinational by default)
//   y_q       out  WIDTH  registered copy of the combinational mux result
//   en_q      out  1      1 when enable_n was 0 at the last non-reset edge
//
// Build option:
//   LS74157_OUTREG_EN - when defined, y is driven from y_q. The function is the
//                       same but arrives one clock later, and y resets to 0.
//                       When undefined, y is purely combinational and does
//                       not depend on clk or rst.

module ls74157_quad_mux #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             select,
    input  logic             enable_n,
    output logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] y_q,
    output logic             en_q
);

    logic [WIDTH-1:0] mux_d;

    // A continuous-assignment ternary propagates X on an unknown select rather
    // than holding a stale value.
    assign mux_d = {WIDTH{~enable_n}} & (select ? b : a);

    always_ff @(posedge clk) begin
        if (rst) begin
            y_q  <= '0;
            en_q <= 1'b0;
        end else begin
            y_q  <= mux_d;
            en_q <= ~enable_n;
        end
    end

`ifdef LS74157_OUTREG_EN
    assign y = y_q;
`else
    assign y = mux_d;
`endif

endmodule

// File: tb/tb_ls74157_quad_mux.sv
// Testbench for ls74157_quad_mux.
//
// The driver applies one directed vector per clock, just after the rising
// edge, and pushes the expected response onto a queue. The expected y of each
// vector is hand-computed. The expected y_q and en_q come from the previous
// vector. A separate monitor pops one entry on every falling edge and compares.
module tb_ls74157_quad_mux;

    localparam int unsigned WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             select;
    logic             enable_n;
    logic [WIDTH-1:0] y;
    logic [WIDTH-1:0] y_q;
    logic             en_q;

    ls74157_quad_mux #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a),
        .b        (b),
        .select   (select),
        .enable_n (enable_n),
        .y        (y),
        .y_q      (y_q),
        .en_q     (en_q)
    );

    always #5 clk = ~clk;

    typedef struct {
        int               idx;
        logic [WIDTH-1:0] y;
        logic [WIDTH-1:0] yq;
        logic             en;
        bit               chk_reg;
    } exp_t;

    exp_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Register contents expected after the most recent edge.
    logic [WIDTH-1:0] mdl_yq;
    logic             mdl_en;
    bit               mdl_valid = 1'b0;
    int               vec_idx   = 0;

    task automatic check_val(input string name, input int idx,
                             input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s vec%0d: got %b, expected %b", name, idx, act, req);
        end
    endtask

    // Drive one vector and queue its expected response. exp_y is the
    // hand-computed combinational result.
    task automatic apply(input logic r, input logic en_n, input logic sel,
                         input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                         input logic [WIDTH-1:0] exp_y);
        exp_t e;
        @(posedge clk);
        #1;
        rst      = r;
        enable_n = en_n;
        select   = sel;
        a        = va;
        b        = vb;
        e.idx     = vec_idx;
        e.yq      = mdl_yq;
        e.en      = mdl_en;
        e.chk_reg = mdl_valid;
`ifdef LS74157_OUTREG_EN
        e.y = mdl_yq;
`else
        e.y = exp_y;
`endif
        exp_q.push_back(e);
        // This vector is captured at the next rising edge.
        mdl_yq    = r ? '0 : exp_y;
        mdl_en    = r ? 1'b0 : ~en_n;
        mdl_valid = 1'b1;
        vec_idx++;
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                if (e.chk_reg || `ifdef LS74157_OUTREG_EN 1'b0 `else 1'b1 `endif)
                    check_val("y", e.idx, y, e.y);
                if (e.chk_reg) begin
                    check_val("y_q", e.idx, y_q, e.yq);
                    check_val("en_q", e.idx, {{(WIDTH-1){1'b0}}, en_q},
                              {{(WIDTH-1){1'b0}}, e.en});
                end
            end
        end
    end

    // Driver
    initial begin
        rst = 1'b1; enable_n = 1'b0; select = 1'b0; a = '0; b = '0;

        // Reset held for two edges.
        apply(1, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        apply(1, 0, 0, 4'b0000, 4'b0000, 4'b0000);
        // Enabled selection patterns.
        apply(0, 0, 0, 4'b0000, 4'b1111, 4'b0000);
        apply(0, 0, 1, 4'b0000, 4'b1111, 4'b1111);
        apply(0, 0, 0, 4'b1010, 4'b0101, 4'b1010);
        apply(0, 0, 1, 4'b1010, 4'b0101, 4'b0101);
        apply(0, 0, 0, 4'b1111, 4'b0000, 4'b1111);
        apply(0, 0, 1, 4'b1111, 4'b0000, 4'b0000);
        apply(0, 0, 0, 4'b0101, 4'b1010, 4'b0101);
        apply(0, 0, 1, 4'b0101, 4'b1010, 4'b1010);
        // Disabled: output forced low in every case.
        apply(0, 1, 0, 4'b0000, 4'b1111, 4'b0000);
        apply(0, 1, 1, 4'b0000, 4'b1111, 4'b0000);
        apply(0, 1, 0, 4'b1010, 4'b0101, 4'b0000);
        apply(0, 1, 1, 4'b1010, 4'b0101, 4'b0000);
        apply(0, 1, 0, 4'b1111, 4'b0000, 4'b0000);
        apply(0, 1, 1, 4'b1111, 4'b0000, 4'b0000);
        apply(0, 1, 0, 4'b0101, 4'b1010, 4'b0000);
        apply(0, 1, 1, 4'b0101, 4'b1010, 4'b0000);
        // Registered path: capture 0110, then disable.
        apply(0, 0, 1, 4'b0000, 4'b0110, 4'b0110);
        apply(0, 1, 1, 4'b0000, 4'b0110, 4'b0000);
        // Mid-operation reset with y_q = 1010.
        apply(0, 0, 0, 4'b1010, 4'b0000, 4'b1010);
        apply(1, 0, 0, 4'b1010, 4'b0000, 4'b1010);
        apply(0, 0, 0, 4'b1010, 4'b0000, 4'b1010);
        apply(0, 0, 0, 4'b1010, 4'b0000, 4'b1010);
        // Select change with a=0011, b=1100.
        apply(0, 0, 0, 4'b0011, 4'b1100, 4'b0011);
        apply(0, 0, 1, 4'b0011, 4'b1100, 4'b1100);
        apply(0, 0, 1, 4'b0011, 4'b1100, 4'b1100);

        // Let the monitor drain the queue, with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending, expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
